// File: rtl/binary_to_gray_counter.sv
`default_nettype none
// ============================================================================
// Module      : binary_to_gray_counter
// Description : Registered up/down binary counter with a registered Gray-code
//               view of the same count. Both views update on the same edge,
//               so they always agree. gray_out changes in exactly one bit per
//               enable step, which makes it safe to sample asynchronously.
//
// Ports       : clk       - single clock, rising edge
//               rst_n     - asynchronous active-low reset (outputs -> 0)
//               clear     - synchronous clear to zero (highest priority)
//               load      - synchronous load of load_bin
//               load_bin  - binary value to load [WIDTH]
//               enable    - advance one step this cycle
//               up_down   - 1 = increment, 0 = decrement
//               bin_out   - registered binary count [WIDTH]
//               gray_out  - registered Gray code of bin_out [WIDTH]
//               wrap      - one-cycle pulse after a rollover step
//
// Revision    : 1.0 - initial release
// ============================================================================
module binary_to_gray_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    input  logic             enable,
    input  logic             up_down,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] c_zero = '0;
    localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] c_max  = '1;

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_wrap;

    logic [WIDTH-1:0] w_bin_next;
    logic [WIDTH-1:0] w_gray_next;
    logic             w_wrap_next;

    // Next-state selection: clear > load > enable step > hold.
    // wrap is only ever raised by an enable step crossing the boundary.
    always_comb begin
        w_bin_next  = r_bin;
        w_wrap_next = 1'b0;
        if (clear) begin
            w_bin_next = c_zero;
        end else if (load) begin
            w_bin_next = load_bin;
        end else if (enable) begin
            if (up_down) begin
                w_bin_next  = r_bin + c_one;
                w_wrap_next = (r_bin == c_max);
            end else begin
                w_bin_next  = r_bin - c_one;
                w_wrap_next = (r_bin == c_zero);
            end
        end
    end

    // Gray encoding of the *next* binary value, so the Gray register is
    // loaded directly and gray_out never has logic between flop and pin.
    assign w_gray_next[WIDTH-1] = w_bin_next[WIDTH-1];

    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_gray_enc
            assign w_gray_next[gi] = w_bin_next[gi+1] ^ w_bin_next[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin  <= c_zero;
            r_gray <= c_zero;
            r_wrap <= 1'b0;
        end else begin
            r_bin  <= w_bin_next;
            r_gray <= w_gray_next;
            r_wrap <= w_wrap_next;
        end
    end

    assign bin_out  = r_bin;
    assign gray_out = r_gray;
    assign wrap     = r_wrap;

endmodule
`default_nettype wire
